// File: rtl/sm_stream_accumulator.sv
// Sign-magnitude stream accumulator: sums COUNT terms in two's complement and
// returns each group total as a saturated sign-magnitude word.
module sm_stream_accumulator #(
   parameter int SIZE  = 16,
   parameter int COUNT = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] out_data,
   output logic            out_sat
);

   localparam int ACC_W = SIZE + $clog2(COUNT) + 1;
   localparam int CNT_W = $clog2(COUNT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);
   localparam logic [ACC_W-1:0] MAG_MAX  = {{(ACC_W-SIZE+1){1'b0}}, {(SIZE-1){1'b1}}};

   typedef enum logic {ST_ACC, ST_HOLD} state_t;

   state_t                  state_reg;
   logic signed [ACC_W-1:0] acc_reg;
   logic [CNT_W-1:0]        cnt_reg;
   logic                    out_valid_reg;
   logic [SIZE-1:0]         out_data_reg;
   logic                    out_sat_reg;

   logic signed [ACC_W-1:0] mag_ext;
   logic signed [ACC_W-1:0] term;
   logic signed [ACC_W-1:0] total;
   logic [ACC_W-1:0]        abs_total;
   logic                    sign_next;
   logic                    sat_next;
   logic [SIZE-2:0]         mag_next;
   logic                    accept;

   assign in_ready  = (state_reg == ST_ACC) && rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_sat   = out_sat_reg;

   // Negative zero decodes to 0 naturally since -0 == 0 in two's complement.
   always_comb begin
      mag_ext   = {{(ACC_W-SIZE+1){1'b0}}, in_data[SIZE-2:0]};
      term      = in_data[SIZE-1] ? -mag_ext : mag_ext;
      total     = acc_reg + term;
      sign_next = total[ACC_W-1];
      abs_total = sign_next ? -total : total;
      sat_next  = (abs_total > MAG_MAX);
   end

   // Saturation forces every magnitude bit high.
   generate
      for (genvar gi = 0; gi < SIZE-1; gi++) begin : g_mag
         assign mag_next[gi] = sat_next | abs_total[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= ST_ACC;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sat_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_ACC: begin
               if (accept) begin
                  if (cnt_reg == LAST_CNT) begin
                     out_data_reg  <= {sign_next, mag_next};
                     out_sat_reg   <= sat_next;
                     out_valid_reg <= 1'b1;
                     state_reg     <= ST_HOLD;
                     acc_reg       <= '0;
                     cnt_reg       <= '0;
                  end else begin
                     acc_reg <= total;
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= ST_ACC;
               end
            end
            default: state_reg <= ST_ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_sm_stream_accumulator.sv
// Scoreboard bench for sm_stream_accumulator (SIZE=16, COUNT=4): integer
// reference model feeds an expected queue drained by an output monitor.
module tb_sm_stream_accumulator;

   localparam int SIZE  = 16;
   localparam int COUNT = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [SIZE-1:0] in_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [SIZE-1:0] out_data;
   logic            out_sat;

   sm_stream_accumulator #(.SIZE(SIZE), .COUNT(COUNT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [16:0] exp_q[$];      // {sat, data}
   int          part_sum    = 0;
   int          part_cnt    = 0;
   int          ready_mode  = 0; // 0: always ready, 1: random, 2: never
   bit          took_prev   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int decode(input logic [15:0] w);
      int m;
      m = int'(w[14:0]);
      return w[15] ? -m : m;
   endfunction

   function automatic logic [16:0] encode(input int s);
      int          a;
      logic        sat;
      logic [14:0] m;
      a   = (s < 0) ? -s : s;
      sat = (a > 32767);
      m   = sat ? 15'h7FFF : a[14:0];
      return {sat, (s < 0), m};
   endfunction

   // Called at a negedge; returns at the negedge following the accept.
   task automatic send(input logic [15:0] d);
      int  guard;
      bit  last;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         miscompares++;
         vectors++;
         $display("FAIL send_timeout: in_ready got 0 expected 1 at %0t", $time);
         in_valid = 1'b0;
         return;
      end
      part_sum += decode(d);
      part_cnt++;
      last = (part_cnt == COUNT);
      if (last) begin
         exp_q.push_back(encode(part_sum));
         part_sum = 0;
         part_cnt = 0;
      end
      @(negedge clk);
      if (last) chk("latency_out_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic group4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
      send(a);
      send(b);
      send(c);
      send(d);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard    = 0;
      in_valid = 1'b0;
      while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst      = 1'b0;
      part_sum = 0;
      part_cnt = 0;
      exp_q.delete();
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_sat",   32'(out_sat),   32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      rst = 1'b1;
   endtask

   // Output monitor: drives out_ready for the coming edge and scores results.
   always @(negedge clk) begin
      if (!rst) begin
         took_prev = 1'b0;
         out_ready = 1'b0;
      end else begin
         if (took_prev) chk("bubble_out_valid", 32'(out_valid), 32'd0);
         took_prev = 1'b0;
         case (ready_mode)
            0:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (out_valid) begin
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_output: got %0h expected none at %0t", out_data, $time);
            end else begin
               chk("out_data", 32'(out_data), 32'(exp_q[0][15:0]));
               chk("out_sat",  32'(out_sat),  32'(exp_q[0][16]));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  took_prev = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      miscompares++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      logic [15:0] d;
      int          r;

      repeat (2) @(negedge clk);
      do_reset();
      @(negedge clk);

      ready_mode = 0;
      group4(16'h0003, 16'h0005, 16'h8002, 16'h0001);   // +7
      drain();
      group4(16'h8064, 16'h8064, 16'h8064, 16'h8064);   // -400
      drain();
      group4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);   // +sat
      drain();
      group4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);   // -sat
      drain();
      group4(16'h0005, 16'h8005, 16'h0000, 16'h8000);   // +0
      drain();
      group4(16'h7FFF, 16'h0000, 16'h8000, 16'h0000);   // exactly max, no sat
      drain();
      group4(16'h7FFF, 16'h0001, 16'h0000, 16'h0000);   // max+1, sat
      drain();
      group4(16'hFFFF, 16'h8001, 16'h0000, 16'h0000);   // -(max+1), sat
      drain();

      // Backpressure: result held while in_valid stays high.
      ready_mode = 2;
      group4(16'h0010, 16'h0020, 16'h0030, 16'h0040);
      in_valid = 1'b1;
      in_data  = 16'h1234;
      repeat (5) begin
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      ready_mode = 0;
      group4(16'h0002, 16'h8001, 16'h0004, 16'h0003);   // +8
      drain();

      // Reset mid-group discards the partial sum.
      send(16'h0010);
      send(16'h0010);
      do_reset();
      @(negedge clk);
      group4(16'h0001, 16'h0001, 16'h0001, 16'h0001);   // +4
      drain();

      // Randomized traffic with input gaps and random backpressure.
      ready_mode = 1;
      for (int g = 0; g < 30; g++) begin
         for (int t = 0; t < COUNT; t++) begin
            r = int'($urandom_range(0, 2));
            if (r != 0) idle(r);
            case ($urandom_range(0, 3))
               0:       d = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 15))};
               1:       d = 16'($urandom);
               2:       d = $urandom_range(0, 1) ? 16'h7FFF : 16'hFFFF;
               default: d = $urandom_range(0, 1) ? 16'h0000 : 16'h8000;
            endcase
            send(d);
         end
      end
      drain();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sm_stream_accumulator.md
Name: sm_stream_accumulator

Overview:
- Consumer-side counterpart of the combinational sign-magnitude adder used in the neuron datapath.
- Takes a valid/ready stream of sign-magnitude words and decodes each into two's complement.
- Accumulates COUNT consecutive terms, then re-encodes the total to sign-magnitude with saturation.
- Sits between the weight×input product stream and the activation stage; delivers one result per group of COUNT terms.

Parameters:
SIZE, 16, word width; bit SIZE-1 is the sign, bits SIZE-2:0 are the magnitude.
COUNT, 8, terms per result; must be ≥ 2.
ACC_W, SIZE+$clog2(COUNT)+1, internal two's complement accumulator width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset: one clock, synchronous, active-low.
in_valid  input  1  in_data holds a term.
in_ready  output  1  block accepts a term this cycle.
in_data  input  SIZE  sign-magnitude term.
out_valid  output  1  out_data/out_sat hold a result.
out_ready  input  1  downstream takes the result.
out_data  output  SIZE  sign-magnitude accumulated result.
out_sat  output  1  result was clipped to ±(2^(SIZE-1)-1).

Behaviour:
- Reset (rst low at a clk edge):
  - state=ACC, acc=0, cnt=0.
  - out_valid=0, out_data=0, out_sat=0.
  - in_ready held 0 while rst is low.
  - Reset mid-group discards partial sums; reset during HOLD drops the pending result.
- States: ACC and HOLD.
  - in_ready = (state==ACC) && rst high.
  - out_valid = (state==HOLD), registered.
- Accept = in_valid && in_ready.
- Decode on accept:
  - mag = in_data[SIZE-2:0], zero-extended to ACC_W.
  - term = in_data[SIZE-1] ? -mag : +mag.
  - Negative zero (0x8000 for SIZE=16) decodes to 0.
- ACC state, accept with cnt < COUNT-1: acc += term, cnt += 1.
- ACC state, accept with cnt == COUNT-1:
  - total = acc + term.
  - Register out_data/out_sat from total; state→HOLD.
  - acc=0, cnt=0.
  - Latency: out_valid rises the cycle after the final accept.
- Encode total:
  - |total| > 2^(SIZE-1)-1 → magnitude all ones, out_sat=1.
  - Otherwise magnitude = |total|, out_sat=0.
  - Sign = total<0. A zero total always encodes as +0 (sign 0).
- HOLD state:
  - out_data and out_sat stay stable; in_ready=0; in_valid is ignored.
  - On out_ready=1: state→ACC next cycle and out_valid drops.
  - One bubble cycle between groups is intended; no same-cycle accept while out_valid is high.
- ACC never overflows: ACC_W covers COUNT·(2^(SIZE-1)-1) in either sign.
- in_valid low in ACC: acc and cnt hold, no timeout.
- out_data/out_sat change only on the transition into HOLD or on reset.

Test Plan (SIZE=16, COUNT=4):
1. Inputs 0x0003, 0x0005, 0x8002, 0x0001 back-to-back, out_ready=1 → out_data=0x0007, out_sat=0, out_valid high for exactly 1 cycle, 1 cycle after the 4th accept.
2. Four inputs of 0x8064 (-100) → out_data=0x8190 (-400), out_sat=0.
3. Four inputs of 0x7FFF → out_data=0x7FFF, out_sat=1. Then four inputs of 0xFFFF → out_data=0xFFFF, out_sat=1.
4. Inputs 0x0005, 0x8005, 0x0000, 0x8000 → out_data=0x0000 (never 0x8000), out_sat=0.
5. Backpressure: hold out_ready=0 for 5 cycles after the result, with in_valid=1 throughout → out_data stable, in_ready=0, no terms consumed. Raise out_ready → in_ready=1 the next cycle and the next group sums correctly.
6. Pull rst low for 1 cycle after 2 of 4 terms (0x0010, 0x0010), then send 0x0001 ×4 → out_data=0x0004; out_valid and outputs are 0 during reset.
